f1_start_lights: RTL and testbench

F1_START_LIGHTS -- requirements
Module: f1_start_lights

---
 rtl/f1_start_lights.sv | 210 +++++++++++++++++++++
 tb/tb_f1_start_lights.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_lights.sv
// F1 start-light sequencer with reaction timer.
// Lights turn on one per tick from bit 0 upward. Once the bank is full, a
// random hold of delay_ticks ticks follows, then all lights go out together
// and the block times how long the driver takes to press stop. Pressing stop
// before lights-out is flagged as a jump start.
//
// Handshake semantics: trigger and stop are plain levels sampled on each
// rising clk edge with no acknowledge. time_out and rt_valid are single-cycle
// strobes, and react_ticks is stable whenever rt_valid is high and until the
// next rt_valid. There is no backpressure, so a consumer must take rt_valid in
// the cycle it is asserted.
module f1_start_lights #(
  parameter int                N_LEDS    = 10,
  parameter int                TICK_DIV  = 50000,
  parameter int                LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'b1100000,
  parameter int                RT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              stop,
  output logic [N_LEDS-1:0] ledr,
  output logic              time_out,
  output logic              jump_start,
  output logic              busy,
  output logic              rt_valid,
  output logic [RT_W-1:0]   react_ticks,
  output logic [LFSR_W-1:0] delay_ticks,
  output logic [2:0]        state_dbg
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_LEDS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] DLY_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [RT_W-1:0]   RT_ONE   = {{(RT_W-1){1'b0}}, 1'b1};
  localparam logic [RT_W-1:0]   RT_MAX   = {RT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LIGHT = 3'd1,
    WAIT  = 3'd2,
    REACT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   pre_cnt;
  logic               tick;
  logic               pre_clr;
  logic [LFSR_W-1:0]  lfsr;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [LFSR_W-1:0]  dly_cnt, dly_n;
  logic [RT_W-1:0]    rcnt, rcnt_n;
  logic [N_LEDS-1:0]  ledr_n;
  logic               time_out_n;
  logic               jump_n;
  logic               rt_valid_n;
  logic [RT_W-1:0]    rt_n;
  logic [LFSR_W-1:0]  delay_n;

  // Tick strobe: one clk per prescaler period.
  assign tick = (pre_cnt == PRE_LAST);

  // Restart the prescaler on LIGHT entry so the first light is a full tick away.
  assign pre_clr = (state_n == LIGHT) && (state != LIGHT);

  // Prescaler counting 0..TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_clr || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  // Free-running Fibonacci LFSR; the delay is sampled from it at the last light.
  // The all-zero lock-up state is escaped by reloading 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= DLY_ONE;
    end else if (lfsr == '0) begin
      lfsr <= DLY_ONE;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // Next-state and next-output logic for the start sequence.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    dly_n      = dly_cnt;
    rcnt_n     = rcnt;
    ledr_n     = ledr;
    time_out_n = 1'b0;
    rt_valid_n = 1'b0;
    jump_n     = jump_start;
    rt_n       = react_ticks;
    delay_n    = delay_ticks;

    case (state)
      IDLE, DONE: begin
        if (trigger) begin
          state_n = LIGHT;
          ledr_n  = '0;
          idx_n   = '0;
          jump_n  = 1'b0;
        end
      end

      LIGHT: begin
        if (stop) begin
          // Moving before the lights are even complete is a jump start.
          state_n = DONE;
          ledr_n  = '0;
          jump_n  = 1'b1;
        end else if (tick) begin
          ledr_n[idx] = 1'b1;
          idx_n       = idx + IDX_ONE;
          if (idx == IDX_LAST) begin
            state_n = WAIT;
            delay_n = lfsr;
            dly_n   = lfsr;
          end
        end
      end

      WAIT: begin
        // stop is checked first so a press on the lights-out tick is a jump start.
        if (stop) begin
          state_n = DONE;
          ledr_n  = '0;
          jump_n  = 1'b1;
        end else if (tick) begin
          if (dly_cnt == DLY_ONE) begin
            state_n    = REACT;
            ledr_n     = '0;
            time_out_n = 1'b1;
            rcnt_n     = '0;
          end else begin
            dly_n = dly_cnt - DLY_ONE;
          end
        end
      end

      REACT: begin
        if (stop) begin
          state_n    = DONE;
          rt_n       = rcnt;
          rt_valid_n = 1'b1;
        end else if (tick) begin
          if (rcnt == RT_MAX) begin
            // Driver never responded: report the saturated count.
            state_n    = DONE;
            rt_n       = RT_MAX;
            rt_valid_n = 1'b1;
          end else begin
            rcnt_n = rcnt + RT_ONE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      dly_cnt     <= '0;
      rcnt        <= '0;
      ledr        <= '0;
      time_out    <= 1'b0;
      jump_start  <= 1'b0;
      rt_valid    <= 1'b0;
      react_ticks <= '0;
      delay_ticks <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      dly_cnt     <= dly_n;
      rcnt        <= rcnt_n;
      ledr        <= ledr_n;
      time_out    <= time_out_n;
      jump_start  <= jump_n;
      rt_valid    <= rt_valid_n;
      react_ticks <= rt_n;
      delay_ticks <= delay_n;
    end
  end

  // A run is in progress in LIGHT, WAIT and REACT.
  assign busy = (state == LIGHT) || (state == WAIT) || (state == REACT);

  // FSM state exposed for observation.
  assign state_dbg = state;

endmodule

// File: tb/tb_f1_start_lights.sv
// Directed bench for f1_start_lights with a small, fast configuration.
module tb_f1_start_lights;

  localparam int              N_LEDS    = 4;
  localparam int              TICK_DIV  = 3;
  localparam int              LFSR_W    = 4;
  localparam logic [3:0]      LFSR_TAPS = 4'b1100;
  localparam int              RT_W      = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LIGHT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_REACT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic              clk;
  logic              rst;
  logic              trigger;
  logic              stop;
  logic [N_LEDS-1:0] ledr;
  logic              time_out;
  logic              jump_start;
  logic              busy;
  logic              rt_valid;
  logic [RT_W-1:0]   react_ticks;
  logic [LFSR_W-1:0] delay_ticks;
  logic [2:0]        state_dbg;

  int checks;
  int failures;

  // Hand-listed 4-bit sequence for taps 1100 starting from 1.
  logic [3:0] lfsr_seq [0:14];
  int         m_cyc;

  f1_start_lights #(
    .N_LEDS   (N_LEDS),
    .TICK_DIV (TICK_DIV),
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .RT_W     (RT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .stop       (stop),
    .ledr       (ledr),
    .time_out   (time_out),
    .jump_start (jump_start),
    .busy       (busy),
    .rt_valid   (rt_valid),
    .react_ticks(react_ticks),
    .delay_ticks(delay_ticks),
    .state_dbg  (state_dbg)
  );

  // Clock and reset-relative edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // From a negedge in IDLE/DONE: pulse trigger and stop at the negedge where
  // the bank has just filled. d is the expected delay for this run.
  task automatic launch_to_wait(output int d);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(12);
    d = int'(lfsr_seq[(m_cyc - 1) % 15]);
  endtask

  task automatic wait_time_out(input int bound, output int c);
    c = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (time_out === 1'b1) begin
        c = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({ledr, time_out, jump_start, rt_valid, react_ticks, delay_ticks, busy, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ledr=%b to=%b js=%b rv=%b rt=%0d dt=%0d busy=%b st=%0d, required all 0",
               ledr, time_out, jump_start, rt_valid, react_ticks, delay_ticks, busy, state_dbg);
    end
    // Release between edges with trigger already high: first edge must act.
    rst = 1'b0;
    trigger = 1'b1;
  endtask

  task automatic test_normal_run();
    int c;
    logic [3:0] exp_l;
    for (int i = 1; i <= 13; i++) begin
      step(1);
      if (i == 1) trigger = 1'b0;
      exp_l = 4'((1 << ((i - 1) / 3)) - 1);
      checks++;
      if (ledr !== exp_l || busy !== 1'b1) begin
        failures++;
        $display("FAIL run_ledr[%0d]: ledr=%b busy=%b, required ledr=%b busy=1", i, ledr, busy, exp_l);
      end
    end
    checks++;
    if (delay_ticks !== 4'd14 || state_dbg !== S_WAIT) begin
      failures++;
      $display("FAIL run_delay: delay_ticks=%0d state=%0d, required 14 / %0d", delay_ticks, state_dbg, S_WAIT);
    end
    wait_time_out(60, c);
    checks++;
    if (c != 42) begin
      failures++;
      $display("FAIL run_time_out_latency: %0d cycles, required 42", c);
    end
    checks++;
    if (ledr !== 4'b0000 || busy !== 1'b1 || state_dbg !== S_REACT) begin
      failures++;
      $display("FAIL run_lights_out: ledr=%b busy=%b state=%0d, required 0000 1 %0d", ledr, busy, state_dbg, S_REACT);
    end
  endtask

  task automatic test_reaction();
    step(1);
    checks++;
    if (time_out !== 1'b0 || rt_valid !== 1'b0) begin
      failures++;
      $display("FAIL react_pulse_width: time_out=%b rt_valid=%b, required 0 0", time_out, rt_valid);
    end
    step(5);
    stop = 1'b1;
    step(1);
    checks++;
    if (rt_valid !== 1'b1 || react_ticks !== 8'd2 || busy !== 1'b0 || state_dbg !== S_DONE) begin
      failures++;
      $display("FAIL react_result: rv=%b rt=%0d busy=%b st=%0d, required 1 2 0 %0d",
               rt_valid, react_ticks, busy, state_dbg, S_DONE);
    end
    stop = 1'b0;
    step(1);
    checks++;
    if (rt_valid !== 1'b0 || react_ticks !== 8'd2) begin
      failures++;
      $display("FAIL react_hold: rv=%b rt=%0d, required 0 2", rt_valid, react_ticks);
    end
  endtask

  task automatic test_jump_start();
    int seen;
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(6);
    checks++;
    if (ledr !== 4'b0011) begin
      failures++;
      $display("FAIL jump_pre_ledr: ledr=%b, required 0011", ledr);
    end
    stop = 1'b1;
    step(1);
    checks++;
    if (jump_start !== 1'b1 || ledr !== 4'b0000 || busy !== 1'b0 || state_dbg !== S_DONE) begin
      failures++;
      $display("FAIL jump_flag: js=%b ledr=%b busy=%b st=%0d, required 1 0000 0 %0d",
               jump_start, ledr, busy, state_dbg, S_DONE);
    end
    stop = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (time_out === 1'b1 || rt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || react_ticks !== 8'd2 || jump_start !== 1'b1) begin
      failures++;
      $display("FAIL jump_quiet: strobes=%0d rt=%0d js=%b, required 0 2 1", seen, react_ticks, jump_start);
    end
  endtask

  task automatic test_retrigger();
    int c;
    int d;
    trigger = 1'b1;
    step(1);
    checks++;
    if (jump_start !== 1'b0 || state_dbg !== S_LIGHT || ledr !== 4'b0000) begin
      failures++;
      $display("FAIL retrig_start: js=%b st=%0d ledr=%b, required 0 %0d 0000", jump_start, state_dbg, ledr, S_LIGHT);
    end
    step(3);
    checks++;
    if (ledr !== 4'b0001) begin
      failures++;
      $display("FAIL retrig_first_light: ledr=%b, required 0001", ledr);
    end
    step(9);
    d = int'(lfsr_seq[(m_cyc - 1) % 15]);
    checks++;
    if (ledr !== 4'b1111 || state_dbg !== S_WAIT || delay_ticks !== 4'(d)) begin
      failures++;
      $display("FAIL retrig_full: ledr=%b st=%0d dt=%0d, required 1111 %0d %0d", ledr, state_dbg, delay_ticks, S_WAIT, d);
    end
    wait_time_out(60, c);
    checks++;
    if (c != 3 * d || state_dbg !== S_REACT) begin
      failures++;
      $display("FAIL retrig_time_out: %0d cycles st=%0d, required %0d %0d", c, state_dbg, 3 * d, S_REACT);
    end
    // Stop before the first reaction tick.
    trigger = 1'b0;
    stop = 1'b1;
    step(1);
    checks++;
    if (rt_valid !== 1'b1 || react_ticks !== 8'd0 || state_dbg !== S_DONE) begin
      failures++;
      $display("FAIL react_zero: rv=%b rt=%0d st=%0d, required 1 0 %0d", rt_valid, react_ticks, state_dbg, S_DONE);
    end
    stop = 1'b0;
  endtask

  task automatic test_jump_at_lights_out();
    int d;
    launch_to_wait(d);
    checks++;
    if (delay_ticks !== 4'(d)) begin
      failures++;
      $display("FAIL edge_delay: dt=%0d, required %0d", delay_ticks, d);
    end
    step(3 * d - 1);
    checks++;
    if (ledr !== 4'b1111 || time_out !== 1'b0) begin
      failures++;
      $display("FAIL edge_pre: ledr=%b to=%b, required 1111 0", ledr, time_out);
    end
    stop = 1'b1;
    step(1);
    checks++;
    if (jump_start !== 1'b1 || time_out !== 1'b0 || rt_valid !== 1'b0 || ledr !== 4'b0000 || state_dbg !== S_DONE) begin
      failures++;
      $display("FAIL edge_jump: js=%b to=%b rv=%b ledr=%b st=%0d, required 1 0 0 0000 %0d",
               jump_start, time_out, rt_valid, ledr, state_dbg, S_DONE);
    end
    stop = 1'b0;
  endtask

  task automatic test_no_response();
    int d;
    int c;
    int n;
    launch_to_wait(d);
    wait_time_out(60, c);
    checks++;
    if (c != 3 * d) begin
      failures++;
      $display("FAIL noresp_time_out: %0d cycles, required %0d", c, 3 * d);
    end
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      step(1);
      if (rt_valid === 1'b1) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 768 || react_ticks !== 8'hFF) begin
      failures++;
      $display("FAIL noresp_timeout: rv after %0d cycles rt=%0h, required 768 ff", n, react_ticks);
    end
    step(1);
    checks++;
    if (rt_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL noresp_after: rv=%b busy=%b, required 0 0", rt_valid, busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int d;
    int c;
    launch_to_wait(d);
    step(2);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ledr, time_out, jump_start, rt_valid, react_ticks, delay_ticks, busy, state_dbg} !== '0) begin
      failures++;
      $display("FAIL wait_reset_async: ledr=%b to=%b js=%b rv=%b rt=%0d dt=%0d busy=%b st=%0d, required all 0",
               ledr, time_out, jump_start, rt_valid, react_ticks, delay_ticks, busy, state_dbg);
    end
    #1 rst = 1'b0;
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(12);
    checks++;
    if (ledr !== 4'b1111 || delay_ticks !== 4'd14) begin
      failures++;
      $display("FAIL wait_reset_lfsr: ledr=%b dt=%0d, required 1111 14", ledr, delay_ticks);
    end
    wait_time_out(60, c);
    checks++;
    if (c != 42) begin
      failures++;
      $display("FAIL wait_reset_time_out: %0d cycles, required 42", c);
    end
  endtask

  task automatic test_reset_mid_react();
    int seen;
    step(2);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (time_out === 1'b1 || rt_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || state_dbg !== S_IDLE || react_ticks !== 8'd0 || ledr !== 4'b0000) begin
      failures++;
      $display("FAIL react_reset_quiet: events=%0d st=%0d rt=%0d ledr=%b, required 0 %0d 0 0000",
               seen, state_dbg, react_ticks, ledr, S_IDLE);
    end
  endtask

  initial begin
    lfsr_seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    checks   = 0;
    failures = 0;
    trigger  = 1'b0;
    stop     = 1'b0;
    test_reset();
    test_normal_run();
    test_reaction();
    test_jump_start();
    test_retrigger();
    test_jump_at_lights_out();
    test_no_response();
    test_reset_in_wait();
    test_reset_mid_react();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
